// File: rtl/instr_fetch_unit.sv
// Single-issue fetch front end: fetches one instruction into the IR, holds it until
// execute accepts it, then resolves the next PC from the decoder's branch verdict.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(32'd4),
  parameter logic [5:0]        HALT_OP  = 6'b111111
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [5:0]        op_code,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              ex_ready,
  input  logic [1:0]        br,
  input  logic              carry,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic [ADDR_W-1:0] imm_offset,
  output logic              link_valid,
  output logic [ADDR_W-1:0] link_addr,
  output logic              halted,
  output logic [31:0]       issue_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e              state_r, next_state_s;
  logic [ADDR_W-1:0]   pc_r, next_pc_s, pc_seq_s, pc_rel_s;
  logic [31:0]         instr_r;
  logic                req_r, req_nxt_s;
  logic                valid_r, valid_nxt_s;
  logic                halted_r, halted_nxt_s;
  logic                link_valid_r, link_valid_nxt_s;
  logic [ADDR_W-1:0]   link_addr_r;
  logic [31:0]         issue_count_r;
  logic                fetch_done_s, fire_s, halt_op_s;

  assign pc_seq_s     = pc_r + PC_STEP;
  assign pc_rel_s     = pc_r + imm_offset;
  assign fetch_done_s = (state_r == FETCH) && imem_ready;
  assign fire_s       = (state_r == ISSUE) && ex_ready;
  assign halt_op_s    = (instr_r[31:26] == HALT_OP);

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      BOOT:  next_state_s = FETCH;
      FETCH: begin
        if (imem_ready) next_state_s = ISSUE;
        else            next_state_s = FETCH;
      end
      ISSUE: begin
        if (ex_ready) next_state_s = halt_op_s ? HALT : FETCH;
        else          next_state_s = ISSUE;
      end
      HALT:    next_state_s = HALT;
      default: next_state_s = BOOT;
    endcase
  end

  // Next-PC selection; a halting instruction leaves the PC where it is
  always_comb begin
    next_pc_s = pc_r;
    if (fire_s && !halt_op_s) begin
      case (br)
        2'b00:   next_pc_s = pc_seq_s;
        2'b01:   next_pc_s = reg_target;
        2'b10:   next_pc_s = carry ? pc_rel_s : pc_seq_s;
        2'b11:   next_pc_s = pc_rel_s;
        default: next_pc_s = pc_seq_s;
      endcase
    end else begin
      next_pc_s = pc_r;
    end
  end

  // Output decode, evaluated one cycle early so every control output comes from a flop
  always_comb begin
    req_nxt_s        = (next_state_s == FETCH);
    valid_nxt_s      = (next_state_s == ISSUE);
    halted_nxt_s     = (next_state_s == HALT);
    link_valid_nxt_s = fire_s && !halt_op_s && (br == 2'b11);
  end

  // State and control-output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= BOOT;
      req_r        <= 1'b0;
      valid_r      <= 1'b0;
      halted_r     <= 1'b0;
      link_valid_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      req_r        <= req_nxt_s;
      valid_r      <= valid_nxt_s;
      halted_r     <= halted_nxt_s;
      link_valid_r <= link_valid_nxt_s;
    end
  end

  // Datapath registers: PC, IR, link address and saturating issue counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r          <= RESET_PC;
      instr_r       <= 32'd0;
      link_addr_r   <= {ADDR_W{1'b0}};
      issue_count_r <= 32'd0;
    end else begin
      pc_r <= next_pc_s;
      if (fetch_done_s) instr_r <= imem_rdata;
      if (fire_s && (issue_count_r != 32'hFFFF_FFFF)) issue_count_r <= issue_count_r + 32'd1;
      if (link_valid_nxt_s) link_addr_r <= pc_seq_s;
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign instr_valid = valid_r;
  assign instr       = instr_r;
  assign op_code     = instr_r[31:26];
  assign pc_out      = pc_r;
  assign link_valid  = link_valid_r;
  assign link_addr   = link_addr_r;
  assign halted      = halted_r;
  assign issue_count = issue_count_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a table of fetch/issue records walks the PC
// through every branch kind, then hand-written sequences cover stall, halt and reset.
module tb_instr_fetch_unit;

  logic        clk, rst, imem_req, imem_ready, instr_valid, ex_ready, carry, link_valid, halted;
  logic [31:0] imem_addr, imem_rdata, instr, pc_out, reg_target, imm_offset, link_addr, issue_count;
  logic [5:0]  op_code;
  logic [1:0]  br;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  br;
    logic        carry;
    logic [31:0] reg_target;
    logic [31:0] imm;
    logic [31:0] exp_next;
    logic        exp_lv;
    logic [31:0] exp_link;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] exp_addr;
  int          exp_count;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .op_code(op_code), .pc_out(pc_out), .ex_ready(ex_ready),
    .br(br), .carry(carry), .reg_target(reg_target), .imm_offset(imm_offset),
    .link_valid(link_valid), .link_addr(link_addr), .halted(halted),
    .issue_count(issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_req();
    for (int k = 0; k < 20 && imem_req !== 1'b1; k++) @(negedge clk);
    chk("req_rise", 32'(imem_req), 32'd1);
  endtask

  // Fetch with two cycles of memory latency, then check the IR is presented
  task automatic fetch_instr(input logic [31:0] addr, input logic [31:0] data);
    wait_req();
    chk("fetch_addr", imem_addr, addr);
    repeat (2) begin
      @(negedge clk);
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_held", imem_addr, addr);
    end
    imem_ready = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    chk("ir_valid", 32'(instr_valid), 32'd1);
    chk("ir_data", instr, data);
    chk("ir_opcode", 32'(op_code), 32'(data[31:26]));
    chk("ir_pc", pc_out, addr);
    chk("ir_req_low", 32'(imem_req), 32'd0);
  endtask

  task automatic issue_instr(input logic [1:0] b, input logic c, input logic [31:0] rt, input logic [31:0] im);
    br         = b;
    carry      = c;
    reg_target = rt;
    imm_offset = im;
    ex_ready   = 1'b1;
    @(negedge clk);
    ex_ready   = 1'b0;
    br         = 2'b00;
    carry      = 1'b0;
    reg_target = 32'd0;
    imm_offset = 32'd0;
  endtask

  initial begin
    vecs[0]  = '{32'h0400_0001, 2'b00, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 1'b0, 32'h0};
    vecs[1]  = '{32'h0800_0002, 2'b01, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'h0000_0008, 1'b0, 32'h0};
    vecs[2]  = '{32'h0C00_0003, 2'b10, 1'b1, 32'h0000_0000, 32'h0000_0010, 32'h0000_0018, 1'b0, 32'h0};
    vecs[3]  = '{32'h1000_0004, 2'b01, 1'b0, 32'h0000_0008, 32'h0000_0000, 32'h0000_0008, 1'b0, 32'h0};
    vecs[4]  = '{32'h1400_0005, 2'b10, 1'b0, 32'h0000_0000, 32'h0000_0010, 32'h0000_000C, 1'b0, 32'h0};
    vecs[5]  = '{32'h1800_0006, 2'b01, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h0000_0020, 1'b0, 32'h0};
    vecs[6]  = '{32'h1C00_0007, 2'b11, 1'b0, 32'h0000_0000, 32'hFFFF_FFF8, 32'h0000_0018, 1'b1, 32'h0000_0024};
    vecs[7]  = '{32'h2000_0008, 2'b01, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'h0000_0040, 1'b0, 32'h0};
    vecs[8]  = '{32'h2400_0009, 2'b01, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'h0000_0100, 1'b0, 32'h0};
    vecs[9]  = '{32'h2800_000A, 2'b01, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFC, 1'b0, 32'h0};
    vecs[10] = '{32'h2C00_000B, 2'b00, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0};
    vecs[11] = '{32'h3000_000C, 2'b11, 1'b0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1'b1, 32'h0000_0004};

    rst = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0; ex_ready = 1'b0;
    br = 2'b00; carry = 1'b0; reg_target = 32'd0; imm_offset = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_count", issue_count, 32'd0);
    chk("rst_link_valid", 32'(link_valid), 32'd0);
    chk("rst_link_addr", link_addr, 32'd0);

    rst = 1'b1;
    #1 chk("boot_req_low", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("boot_req_rise", 32'(imem_req), 32'd1);

    exp_addr  = 32'd0;
    exp_count = 0;
    for (int i = 0; i < 12; i++) begin
      fetch_instr(exp_addr, vecs[i].instr);
      // Branch operands and memory data outside their qualifying cycle must be ignored
      br = 2'b01; reg_target = 32'hDEAD_BEE0; carry = 1'b1; imm_offset = 32'h0000_0100;
      imem_ready = 1'b1; imem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      imem_ready = 1'b0; imem_rdata = 32'd0;
      chk("hold_instr", instr, vecs[i].instr);
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_count", issue_count, 32'(exp_count));
      issue_instr(vecs[i].br, vecs[i].carry, vecs[i].reg_target, vecs[i].imm);
      exp_count++;
      chk("post_valid", 32'(instr_valid), 32'd0);
      chk("post_req", 32'(imem_req), 32'd1);
      chk("next_addr", imem_addr, vecs[i].exp_next);
      chk("link_valid", 32'(link_valid), 32'(vecs[i].exp_lv));
      if (vecs[i].exp_lv) chk("link_addr", link_addr, vecs[i].exp_link);
      chk("issue_count", issue_count, 32'(exp_count));
      @(negedge clk);
      chk("link_pulse_end", 32'(link_valid), 32'd0);
      exp_addr = vecs[i].exp_next;
    end

    // Execute stalls for five cycles
    fetch_instr(32'hFFFF_FFF0, 32'h0800_0123);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_instr", instr, 32'h0800_0123);
      chk("stall_opcode", 32'(op_code), 32'h0000_0002);
      chk("stall_pc", pc_out, 32'hFFFF_FFF0);
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_count", issue_count, 32'd12);
    end
    issue_instr(2'b00, 1'b0, 32'd0, 32'd0);
    chk("stall_next_addr", imem_addr, 32'hFFFF_FFF4);
    chk("stall_post_count", issue_count, 32'd13);

    // Halt opcode: branch verdict ignored, fetch stops for good
    fetch_instr(32'hFFFF_FFF4, 32'hFC00_0000);
    chk("halt_opcode", 32'(op_code), 32'h0000_003F);
    issue_instr(2'b11, 1'b0, 32'h0000_0500, 32'h0000_0040);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_req", 32'(imem_req), 32'd0);
    chk("halt_valid", 32'(instr_valid), 32'd0);
    chk("halt_pc", imem_addr, 32'hFFFF_FFF4);
    chk("halt_count", issue_count, 32'd14);
    chk("halt_no_link", 32'(link_valid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      imem_ready = k[0];
      ex_ready   = 1'b1;
      @(negedge clk);
      chk("halt_stay_req", 32'(imem_req), 32'd0);
      chk("halt_stay_flag", 32'(halted), 32'd1);
      chk("halt_stay_valid", 32'(instr_valid), 32'd0);
    end
    imem_ready = 1'b0;
    ex_ready   = 1'b0;

    // Reset out of halt, then reset again in the middle of a fetch
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_req();
    chk("refetch_addr", imem_addr, 32'd0);
    chk("refetch_halted", 32'(halted), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("req_drop_async", 32'(imem_req), 32'd0);
    imem_ready = 1'b1;
    imem_rdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_instr", instr, 32'd0);
    chk("midrst_count", issue_count, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    chk("boot_ignores_ready", 32'(instr_valid), 32'd0);
    chk("boot_then_req", 32'(imem_req), 32'd1);
    fetch_instr(32'd0, 32'h0C00_0042);
    issue_instr(2'b00, 1'b0, 32'd0, 32'd0);
    chk("after_rst_addr", imem_addr, 32'h0000_0004);
    chk("after_rst_count", issue_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
